// File: rtl/mem_bus_if_if.sv
// MEM-side bus port between the memory controller (master) and the bus
// interface unit (slave). READ is rw = 1, WRITE is rw = 0.
interface simple_bus_io;
    logic [29:0] addr;
    logic        as_;
    logic        rw;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output addr, output as_, output rw, output wr_data, input rd_data);
    modport slave  (input addr, input as_, input rw, input wr_data, output rd_data);
endinterface

// File: rtl/mem_bus_if.sv
// Bus interface unit for the MEM stage: turns single-cycle core requests into
// arbitrated, handshaked system-bus transfers and captures read data.
module mem_bus_if (
    input  logic        clk,
    input  logic        reset_,
    simple_bus_io.slave core,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    output logic        bus_req_,
    input  logic        bus_grnt_,
    output logic [29:0] bus_addr,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_
);

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_bus_req_;
    logic        r_bus_as_;
    logic        r_bus_rw;
    logic [29:0] r_bus_addr;
    logic [31:0] r_bus_wr_data;
    logic [31:0] r_rd_buf;
    logic        w_busy;
    logic [31:0] w_rd_data;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_rd_data    = r_rd_buf;
        case (r_state)
            IDLE: begin
                if (!core.as_ && !flush) begin
                    w_next_state = REQ;
                    w_busy       = 1'b1;
                end
            end
            REQ: begin
                w_busy = 1'b1;
                if (flush) begin
                    w_next_state = IDLE;
                end else if (!bus_grnt_) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                // Completion cycle forwards slave data straight to the core.
                if (bus_rdy_) begin
                    w_busy = 1'b1;
                end else begin
                    w_rd_data    = bus_rd_data;
                    w_next_state = stall ? STALL : IDLE;
                end
            end
            STALL: begin
                if (!stall) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_bus_req_    <= 1'b1;
            r_bus_as_     <= 1'b1;
            r_bus_rw      <= READ;
            r_bus_addr    <= '0;
            r_bus_wr_data <= '0;
            r_rd_buf      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!core.as_ && !flush) begin
                        r_bus_req_    <= 1'b0;
                        r_bus_addr    <= core.addr;
                        r_bus_rw      <= core.rw;
                        r_bus_wr_data <= core.wr_data;
                    end
                end
                REQ: begin
                    if (flush) begin
                        r_bus_req_ <= 1'b1;
                    end else if (!bus_grnt_) begin
                        r_bus_as_ <= 1'b0;
                    end
                end
                ACCESS: begin
                    // Strobe is a single-cycle pulse; flush cannot cancel a started transfer.
                    r_bus_as_ <= 1'b1;
                    if (!bus_rdy_) begin
                        r_bus_req_    <= 1'b1;
                        r_bus_addr    <= '0;
                        r_bus_wr_data <= '0;
                        r_bus_rw      <= READ;
                        if (r_bus_rw == READ) begin
                            r_rd_buf <= bus_rd_data;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy         = w_busy;
    assign core.rd_data = w_rd_data;
    assign bus_req_     = r_bus_req_;
    assign bus_as_      = r_bus_as_;
    assign bus_rw       = r_bus_rw;
    assign bus_addr     = r_bus_addr;
    assign bus_wr_data  = r_bus_wr_data;

endmodule

// File: doc/mem_bus_if.md
# mem_bus_if

Bus interface unit for the MEM stage: it sits directly downstream of the MEM-stage memory controller and turns that controller's single-cycle bus master requests into arbitrated, handshaked transfers on the shared system bus. It owns bus request and grant, address strobe timing, and read-data capture. It raises `busy` so the pipeline stalls until the transfer completes. It also holds read data stable while the pipeline is stalled for other reasons.

## Interface
Parameters: none. Widths come from `cpu.vh`: `WordData` is 32 bits, `WordAddr` is 30 bits.
- clk  in  1  system clock; all state updates on the rising edge
- reset_  in  1  asynchronous, active-low reset
- core  simple_bus_io.slave  —  MEM-side port, driven by the memory controller:
  - addr: 30 bits
  - as_: active low
  - rw: `READ` = 1, `WRITE` = 0
  - wr_data: 32 bits
  - rd_data: 32 bits, driven by this block
- stall  in  1  pipeline stall from the pipeline controller
- flush  in  1  pipeline flush from the pipeline controller
- busy  out  1  transfer in progress; the pipeline controller must stall
- bus_req_  out  1  bus request to the arbiter, active low, registered
- bus_grnt_  in  1  bus grant from the arbiter, active low
- bus_addr  out  30  word address, registered
- bus_as_  out  1  address strobe, active low, registered
- bus_rw  out  1  read/write, registered
- bus_wr_data  out  32  write data, registered
- bus_rd_data  in  32  read data from the selected slave
- bus_rdy_  in  1  transfer complete, active low

## Operation
States: IDLE, REQ, ACCESS, STALL.

**IDLE**
- If core.as_ = 0 and flush = 0:
  - register bus_req_ = 0, bus_addr = core.addr, bus_rw = core.rw, bus_wr_data = core.wr_data;
  - go to REQ.

**REQ**
- If flush = 1: bus_req_ ← 1, go to IDLE. The transfer is abandoned and nothing is driven on the bus.
- Else if bus_grnt_ = 0: bus_as_ ← 0, go to ACCESS.
- Otherwise hold.

**ACCESS**
- bus_as_ ← 1 on the first ACCESS edge, so bus_as_ is low for exactly one cycle per transfer.
- Wait for bus_rdy_ = 0. On that cycle:
  - bus_req_ ← 1, bus_addr ← 0, bus_wr_data ← 0, bus_rw ← `READ`;
  - if bus_rw was `READ`, rd_buf ← bus_rd_data;
  - next state is STALL if stall = 1, else IDLE.
- flush has no effect in ACCESS: a started transfer always completes, and a write is always performed.

**STALL**
- Return to IDLE on the first cycle with stall = 0. New requests are not accepted while in STALL.

**Combinational outputs**
- busy = 1 when:
  - (IDLE and core.as_ = 0 and flush = 0), or
  - REQ, or
  - (ACCESS and bus_rdy_ = 1).
- busy = 0 otherwise, including in STALL.
- core.rd_data = bus_rd_data when in ACCESS with bus_rdy_ = 0; otherwise rd_buf.
- Write transfers leave rd_buf unchanged.

**Reset values** (asynchronous, while reset_ = 0)
- state = IDLE
- bus_req_ = 1, bus_as_ = 1, bus_rw = `READ`
- bus_addr = 0, bus_wr_data = 0, rd_buf = 0
- Consequently busy = 0 and core.rd_data = 0 unless core.as_ is asserted.

**Reset mid-transfer**
- All bus outputs return to their idle values immediately and the transfer is dropped. Slaves must tolerate loss of bus_req_.

## Timing
- Fastest transfer, with bus_grnt_ already low and a zero-wait slave:
  - cycle 0: IDLE, core.as_ = 0, busy = 1;
  - cycle 1: REQ, bus_req_ = 0, grant seen, busy = 1;
  - cycle 2: ACCESS, bus_as_ = 0, bus_rdy_ = 0, core.rd_data = bus_rd_data, busy = 0.
- Latency is 3 cycles, plus 1 cycle per cycle of grant delay, plus 1 cycle per slave wait cycle.
- core.addr, core.rw and core.wr_data are sampled only in IDLE. Later changes are ignored until the transfer ends.
- bus_req_ stays low from REQ entry through the bus_rdy_ cycle. The arbiter may re-grant on the next cycle.
- Back-to-back accesses: after completion the block is in IDLE, and the next core.as_ starts a new REQ one cycle later. There is no request pipelining.
- If stall and bus_rdy_ occur in the same cycle, the block goes to STALL. rd_buf stays stable on core.rd_data until stall clears.

## Test plan
- Read, grant already low, zero-wait slave returning 32'hDEADBEEF at addr 30'h100:
  - bus_as_ is low exactly in cycle 2;
  - busy is 1,1,0;
  - core.rd_data = 32'hDEADBEEF in cycle 2 and still holds that value from rd_buf afterwards.
- Write of 32'h12345678 to 30'h3FF, grant delayed 3 cycles, slave with 2 wait cycles:
  - bus_wr_data and bus_addr are stable for the whole transfer;
  - bus_rw = 0;
  - busy is high for 7 cycles;
  - rd_buf is unchanged.
- flush asserted while in REQ before grant:
  - bus_req_ returns to 1 next cycle;
  - bus_as_ never asserts;
  - state is IDLE and busy = 0.
- flush asserted in ACCESS during a write: the write still completes with bus_rdy_, and busy follows the normal rules.
- stall high at bus_rdy_ for a read of 32'hA5A5A5A5, held 4 cycles:
  - state is STALL, busy = 0;
  - core.rd_data = 32'hA5A5A5A5 throughout;
  - core.as_ is ignored until stall clears, then IDLE.
- reset_ driven low mid-ACCESS:
  - bus_req_, bus_as_ and bus_rw go to 1 and bus_addr to 0 without waiting for a clock edge;
  - after release the block is idle and a new read completes normally.
